outerprodrc_drain: RTL and testbench
====================================

Name: outerprodrc_drain

Overview:
- Run controller and result drain that sits directly downstream of the unary outer-product array.
- Sequences one bitstream run: clear, enable for RUNCYC cycles, settle. The array's per-element binary accumulators are never cleared except by reset, so the block computes each element's delta over the run.
- Each delta is shifted, optionally ReLU'd and saturated, then streamed out element-by-element on a valid/ready interface.

Parameters:
ROWNUM, 4, rows of the array
COLNUM, 4, columns of the array
OUTBITWIDTH, 16, width of each array accumulator element
RUNCYC, 256, enabled cycles per run (bitstream length), >=1
SETTLE, 1, idle cycles after the last enabled cycle before the final accumulators are sampled, >=1
SHIFT, 0, arithmetic right shift applied to each delta, 0..OUTBITWIDTH-1
RESBITWIDTH, 8, signed result width, <= OUTBITWIDTH
RELU, 0, 1 = clamp negative results to 0

Ports:
iClk  in  1  clock
iRstN  in  1  asynchronous active-low reset
iStart  in  1  start a run; sampled only in IDLE
oBusy  out  1  high in every state except IDLE
oEn  out  1  enable to the array
oClr  out  1  clear to the array bit generators
iAcc  in  ROWNUM*COLNUM*OUTBITWIDTH  array accumulators; element e=i*COLNUM+j at bits [e*OUTBITWIDTH +: OUTBITWIDTH]
oValid  out  1  result valid
iReady  in  1  consumer ready
oData  out  RESBITWIDTH  signed result
oIdx  out  clog2(ROWNUM*COLNUM) (min 1)  element index of oData
oLast  out  1  high with the final element (idx N-1, N=ROWNUM*COLNUM)
oDone  out  1  one-cycle pulse after the last element handshake

Behaviour:
- Reset, asynchronous and active-low, forces IDLE and zeroes all outputs, counters, the base snapshot and the result buffer. A reset mid-run or mid-drain aborts that run; no partial output.
- FSM states: IDLE, CLR, RUN, WAIT, CAP, DRAIN, DONE.
- IDLE: on iStart go to CLR. iStart in any other state is ignored and not queued.
- CLR (1 cycle):
  - oClr=1, oEn=0.
  - Snapshot all N iAcc elements into base registers.
  - Go to RUN.
- RUN (exactly RUNCYC cycles):
  - oEn=1, counter runs 0..RUNCYC-1.
  - On the cycle with count RUNCYC-1, go to WAIT.
- WAIT (SETTLE cycles): oEn=0. Then go to CAP.
- CAP (1 cycle):
  - Per element, delta = iAcc - base modulo 2^OUTBITWIDTH, interpreted as signed two's complement.
  - r = delta >>> SHIFT (arithmetic, floor).
  - If RELU and r<0, r=0.
  - Saturate r to [-2^(RESBITWIDTH-1), 2^(RESBITWIDTH-1)-1].
  - Store into an N-entry result buffer; go to DRAIN with idx=0.
- DRAIN:
  - oValid=1, oData=buf[idx], oIdx=idx, oLast=(idx==N-1).
  - Transfer occurs on a cycle with oValid&iReady; then idx increments.
  - oData, oIdx and oLast are held stable while oValid&~iReady.
  - A transfer with oLast goes to DONE; oValid drops the next cycle, with no bubble-free restart.
- DONE (1 cycle): oDone=1, then IDLE. An iStart on the DONE cycle is ignored.
- Accumulator wrap within a run is handled by the modular subtraction. The delta is correct provided |true delta| < 2^(OUTBITWIDTH-1).
- oEn and oClr are registered outputs (state-decoded flops), never high simultaneously.
- Run latency: 1 (CLR) + RUNCYC + SETTLE + 1 (CAP) cycles from iStart sampled to first oValid.

Test Plan:
- Basic run (RUNCYC=4, SETTLE=1, SHIFT=0, RESBITWIDTH=8): iStart; base elem0=100, final elem0=130 -> oEn high exactly 4 cycles, oClr 1 cycle before, first oValid 7 cycles after iStart sampled, idx0 oData=30.
- Saturation and sign: base=100, final=400 -> oData=127; base=10, final=5 -> oData=0xFB (-5); with RELU=1 the latter gives 0.
- Wrap and shift: base=65530, final=4 -> delta 10, SHIFT=1 -> 5; base=0, final=65533 (delta -3) with SHIFT=1 -> -2.
- Backpressure: iReady low 3 cycles on idx 2 -> oData/oIdx held; all 16 indices delivered in order 0..15 once, oLast only on 15, oDone one pulse after.
- Ignored starts: iStart pulsed during RUN and DRAIN -> no effect on counts or sequence; iStart after returning to IDLE starts a new run with a fresh base.
- Reset mid-RUN and mid-DRAIN: iRstN low -> immediately oEn=oValid=oBusy=0, oData=0; a subsequent iStart runs normally.

Source files
------------

// File: rtl/outerprodrc_drain.sv
// outerprodrc_drain: run controller and result drain for the unary outer-product array.
// Sequences one bitstream run (clear, enable RUNCYC cycles, settle), then turns each
// element's accumulator delta over the run into a shifted, optionally ReLU'd, saturated
// signed result. The results are streamed out one element at a time on valid/ready.
//
// Ports:
//   iClk, iRstN   clock, asynchronous active-low reset
//   iStart        start a run (sampled only while idle)
//   oBusy         high whenever not idle
//   oEn, oClr     registered enable / clear to the array
//   iAcc          packed array accumulators, element e at [e*OUTBITWIDTH +: OUTBITWIDTH]
//   oValid/iReady result stream handshake
//   oData, oIdx   signed result and its element index
//   oLast         marks element N-1
//   oDone         one-cycle pulse after the final handshake
module outerprodrc_drain #(
  parameter int unsigned ROWNUM      = 4,
  parameter int unsigned COLNUM      = 4,
  parameter int unsigned OUTBITWIDTH = 16,
  parameter int unsigned RUNCYC      = 256,
  parameter int unsigned SETTLE      = 1,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned RESBITWIDTH = 8,
  parameter int unsigned RELU        = 0,
  localparam int unsigned IdxW = (ROWNUM * COLNUM > 1) ? $clog2(ROWNUM * COLNUM) : 1
) (
  input  logic                                   iClk,
  input  logic                                   iRstN,
  input  logic                                   iStart,
  output logic                                   oBusy,
  output logic                                   oEn,
  output logic                                   oClr,
  input  logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]   iAcc,
  output logic                                   oValid,
  input  logic                                   iReady,
  output logic signed [RESBITWIDTH-1:0]          oData,
  output logic [IdxW-1:0]                        oIdx,
  output logic                                   oLast,
  output logic                                   oDone
);

  localparam int unsigned N      = ROWNUM * COLNUM;
  localparam int unsigned CntMax = (RUNCYC > SETTLE) ? RUNCYC : SETTLE;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] RunLast = CntW'(RUNCYC - 1);
  localparam logic [CntW-1:0] SetLast = CntW'(SETTLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  // Saturation bounds expressed at accumulator width so the compare stays signed.
  localparam logic signed [OUTBITWIDTH-1:0] ResMax =
      {{(OUTBITWIDTH - RESBITWIDTH + 1){1'b0}}, {(RESBITWIDTH - 1){1'b1}}};
  localparam logic signed [OUTBITWIDTH-1:0] ResMin = ~ResMax;

  typedef enum logic [2:0] {
    StIdle, StClr, StRun, StWait, StCap, StDrain, StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    en_q, clr_q;
  logic [OUTBITWIDTH-1:0]  base_q [N];
  logic [RESBITWIDTH-1:0]  res_q  [N];

  // Modular delta, arithmetic shift, optional ReLU, then saturation.
  function automatic logic [RESBITWIDTH-1:0] shape(input logic [OUTBITWIDTH-1:0] acc,
                                                   input logic [OUTBITWIDTH-1:0] base);
    logic signed [OUTBITWIDTH-1:0] delta;
    logic signed [OUTBITWIDTH-1:0] r;
    delta = acc - base;
    r     = delta >>> SHIFT;
    if (RELU != 0 && r[OUTBITWIDTH-1]) r = '0;
    if (r > ResMax)      r = ResMax;
    else if (r < ResMin) r = ResMin;
    return r[RESBITWIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: if (iStart) state_d = StClr;
      StClr: begin
        state_d = StRun;
        cnt_d   = '0;
      end
      StRun: begin
        if (cnt_q == RunLast) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == SetLast) state_d = StCap;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StCap: begin
        state_d = StDrain;
        idx_d   = '0;
      end
      StDrain: begin
        if (iReady) begin
          if (idx_q == IdxLast) state_d = StDone;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      for (int e = 0; e < N; e++) begin
        base_q[e] <= '0;
        res_q[e]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      // Decoded from the next state so the flops line up with the state they mark.
      en_q    <= (state_d == StRun);
      clr_q   <= (state_d == StClr);
      if (state_q == StClr) begin
        for (int e = 0; e < N; e++) base_q[e] <= iAcc[e*OUTBITWIDTH +: OUTBITWIDTH];
      end
      if (state_q == StCap) begin
        for (int e = 0; e < N; e++) res_q[e] <= shape(iAcc[e*OUTBITWIDTH +: OUTBITWIDTH],
                                                      base_q[e]);
      end
    end
  end

  always_comb begin
    oBusy  = (state_q != StIdle);
    oEn    = en_q;
    oClr   = clr_q;
    oValid = (state_q == StDrain);
    oDone  = (state_q == StDone);
    oData  = oValid ? res_q[idx_q] : '0;
    oIdx   = oValid ? idx_q : '0;
    oLast  = oValid && (idx_q == IdxLast);
  end

endmodule

// File: tb/tb_outerprodrc_drain.sv
module tb_outerprodrc_drain;

  localparam int N  = 16;
  localparam int OW = 16;
  localparam int RC = 4;
  localparam int ST = 1;

  logic            iClk = 1'b0;
  logic            iRstN, iStart, iReady;
  logic [N*OW-1:0] iAcc;
  logic            busy [3];
  logic            en   [3];
  logic            clr  [3];
  logic            valid[3];
  logic            last [3];
  logic            done [3];
  logic [7:0]      data [3];
  logic [3:0]      idx  [3];

  int n_cmp = 0;
  int n_bad = 0;
  int base_v[N];
  int fin_v [N];

  // Three variants: plain, SHIFT=1, RELU=1; all see the same stimulus.
  outerprodrc_drain #(.RUNCYC(RC), .SETTLE(ST), .SHIFT(0), .RELU(0)) u_dut0 (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .oBusy(busy[0]), .oEn(en[0]),
    .oClr(clr[0]), .iAcc(iAcc), .oValid(valid[0]), .iReady(iReady), .oData(data[0]),
    .oIdx(idx[0]), .oLast(last[0]), .oDone(done[0]));
  outerprodrc_drain #(.RUNCYC(RC), .SETTLE(ST), .SHIFT(1), .RELU(0)) u_dut1 (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .oBusy(busy[1]), .oEn(en[1]),
    .oClr(clr[1]), .iAcc(iAcc), .oValid(valid[1]), .iReady(iReady), .oData(data[1]),
    .oIdx(idx[1]), .oLast(last[1]), .oDone(done[1]));
  outerprodrc_drain #(.RUNCYC(RC), .SETTLE(ST), .SHIFT(0), .RELU(1)) u_dut2 (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .oBusy(busy[2]), .oEn(en[2]),
    .oClr(clr[2]), .iAcc(iAcc), .oValid(valid[2]), .iReady(iReady), .oData(data[2]),
    .oIdx(idx[2]), .oLast(last[2]), .oDone(done[2]));

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the run's true delta.
  function automatic int model(input int b, input int f, input int sh, input bit relu);
    int d;
    d = (f - b) & 32'hffff;
    if (d >= 32768) d -= 65536;
    d = d >>> sh;
    if (relu && d < 0) d = 0;
    if (d > 127)  d = 127;
    if (d < -128) d = -128;
    return d & 8'hff;
  endfunction

  task automatic set_acc(input bit use_fin);
    for (int e = 0; e < N; e++) begin
      iAcc[e*OW +: OW] = use_fin ? fin_v[e][15:0] : base_v[e][15:0];
    end
  endtask

  task automatic gen_random();
    int d;
    for (int e = 0; e < N; e++) begin
      base_v[e] = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 2000)) - 1000;
      else                           d = int'($urandom_range(0, 300)) - 150;
      fin_v[e] = (base_v[e] + d) & 32'hffff;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},  busy[0],  0);
    chk({tag, "_en"},    en[0],    0);
    chk({tag, "_clr"},   clr[0],   0);
    chk({tag, "_valid"}, valid[0], 0);
    chk({tag, "_data"},  data[0],  0);
    chk({tag, "_idx"},   idx[0],   0);
    chk({tag, "_last"},  last[0],  0);
    chk({tag, "_done"},  done[0],  0);
  endtask

  task automatic run(input int stall_idx, input bit poke);
    int lat, en_cnt, clr_cnt, both_cnt, exp_idx, stall_left, budget;
    bit switched;
    set_acc(0);
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    chk("busy_after_start", busy[0], 1);
    lat = 0; en_cnt = 0; clr_cnt = 0; both_cnt = 0; switched = 0;
    while (!valid[0] && lat < 100) begin
      if (clr[0]) clr_cnt++;
      if (en[0] && clr[0]) both_cnt++;
      if (en[0]) begin
        en_cnt++;
        if (!switched) begin
          set_acc(1);
          switched = 1;
        end
      end
      iStart = poke & en[0];
      @(negedge iClk);
      lat++;
    end
    iStart = 1'b0;
    chk("latency",        lat,      1 + RC + ST + 1);
    chk("en_cycles",      en_cnt,   RC);
    chk("clr_cycles",     clr_cnt,  1);
    chk("en_clr_overlap", both_cnt, 0);
    exp_idx = 0; stall_left = 3; budget = 0;
    while (exp_idx < N && budget < 200) begin
      chk("valid",  valid[0], 1);
      chk("idx",    idx[0],   exp_idx);
      chk("last",   last[0],  exp_idx == N - 1);
      chk("data_s0", data[0], model(base_v[exp_idx], fin_v[exp_idx], 0, 0));
      chk("data_sh", data[1], model(base_v[exp_idx], fin_v[exp_idx], 1, 0));
      chk("data_rl", data[2], model(base_v[exp_idx], fin_v[exp_idx], 0, 1));
      chk("done_in_drain", done[0], 0);
      if (exp_idx == stall_idx && stall_left > 0) begin
        iReady = 1'b0;
        stall_left--;
      end else begin
        iReady = ($urandom_range(0, 3) != 0);
      end
      iStart = poke;
      if (iReady) exp_idx++;
      @(negedge iClk);
      budget++;
    end
    iReady = 1'b0;
    chk("all_delivered", exp_idx, N);
    chk("valid_after_last", valid[0], 0);
    chk("done_pulse", done[0], 1);
    chk("busy_in_done", busy[0], 1);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    chk("done_one_cycle", done[0], 0);
    chk("idle_after_done", busy[0], 0);
    @(negedge iClk);
    chk("start_on_done_ignored", clr[0], 0);
    chk("still_idle", busy[0], 0);
  endtask

  task automatic reset_mid(input bit in_drain);
    int budget;
    gen_random();
    set_acc(0);
    @(negedge iClk); iStart = 1'b1;
    @(negedge iClk); iStart = 1'b0;
    budget = 0;
    while (!(in_drain ? valid[0] : en[0]) && budget < 100) begin
      @(negedge iClk);
      budget++;
    end
    chk("reset_reach", budget < 100, 1);
    if (in_drain) begin
      iReady = 1'b1;
      repeat (2) @(negedge iClk);
      iReady = 1'b0;
    end else begin
      @(negedge iClk);
    end
    iRstN = 1'b0;
    #1;
    check_outputs_zero(in_drain ? "rst_drain" : "rst_run");
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  initial begin
    iRstN = 1'b0; iStart = 1'b0; iReady = 1'b0; iAcc = '0;
    repeat (2) @(negedge iClk);
    check_outputs_zero("reset");
    iRstN = 1'b1;

    // Directed corner values on the first elements, random elsewhere.
    gen_random();
    base_v[0] = 100;   fin_v[0] = 130;
    base_v[1] = 100;   fin_v[1] = 400;
    base_v[2] = 10;    fin_v[2] = 5;
    base_v[3] = 65530; fin_v[3] = 4;
    base_v[4] = 0;     fin_v[4] = 65533;
    run(2, 0);

    gen_random();
    run(2, 1);

    gen_random();
    run(-1, 0);

    reset_mid(0);
    reset_mid(1);

    gen_random();
    run(5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
